// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter sharing one L2 request/response port among NUM_REQ L1 miss handlers.
// Optional watchdog on the L2 wait phase is enabled by defining L2ARB_WATCHDOG_EN.
module l2_req_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int PADDR_WIDTH    = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_clear,
  input  logic [NUM_REQ-1:0]             i_req,
  output logic [NUM_REQ-1:0]             o_grant,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*PADDR_WIDTH-1:0] i_req_paddr,
  input  logic [NUM_REQ-1:0]             i_req_cached,
  output logic [NUM_REQ-1:0]             o_returned,
  output logic [DATA_WIDTH-1:0]          o_returned_data,
  output logic                           o_l2_valid,
  output logic [PADDR_WIDTH-1:0]         o_l2_paddr,
  output logic                           o_l2_cached,
  input  logic                           i_l2_ready,
  input  logic                           i_l2_resp_valid,
  input  logic [DATA_WIDTH-1:0]          i_l2_resp_data,
  output logic                           o_busy,
  output logic                           o_timeout
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_CAPTURE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RETURN
  } arb_state_t;

  arb_state_t              state_reg, state_next;
  logic [OWN_W-1:0]        owner_reg, owner_next;
  logic [OWN_W-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [OWN_W-1:0]        owner_inc;
  logic                    discard_reg, discard_next;
  logic                    l2_valid_next;
  logic [PADDR_WIDTH-1:0]  l2_paddr_next;
  logic                    l2_cached_next;
  logic [NUM_REQ-1:0]      returned_next;
  logic [DATA_WIDTH-1:0]   returned_data_next;
  logic                    win_found;
  logic [OWN_W-1:0]        win_idx;
  logic [PADDR_WIDTH-1:0]  req_paddr_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_paddr
    assign req_paddr_arr[gi] = i_req_paddr[gi*PADDR_WIDTH +: PADDR_WIDTH];
  end

  // Index base+ofs wrapped into 0..NUM_REQ-1 (works for non power-of-two counts).
  function automatic logic [OWN_W-1:0] rr_idx(input logic [OWN_W-1:0] base, input int ofs);
    int k;
    k = int'(base) + ofs;
    if (k >= NUM_REQ) k = k - NUM_REQ;
    return OWN_W'(k);
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && i_req[rr_idx(rr_ptr_reg, i)]) begin
        win_found = 1'b1;
        win_idx   = rr_idx(rr_ptr_reg, i);
      end
    end
  end

  assign owner_inc = rr_idx(owner_reg, 1);
  assign o_busy    = (state_reg != ARB_IDLE);

  always_comb begin
    state_next         = state_reg;
    owner_next         = owner_reg;
    rr_ptr_next        = rr_ptr_reg;
    discard_next       = discard_reg;
    l2_valid_next      = o_l2_valid;
    l2_paddr_next      = o_l2_paddr;
    l2_cached_next     = o_l2_cached;
    returned_next      = '0;
    returned_data_next = '0;
    o_grant            = '0;
    case (state_reg)
      ARB_IDLE: begin
        if (!i_clear && win_found) begin
          o_grant[win_idx] = 1'b1;
          owner_next       = win_idx;
          state_next       = ARB_CAPTURE;
        end
      end
      ARB_CAPTURE: begin
        if (i_clear) begin
          l2_valid_next = 1'b0;
          state_next    = ARB_IDLE;
        end else if (i_req_valid[owner_reg]) begin
          l2_paddr_next  = req_paddr_arr[owner_reg];
          l2_cached_next = i_req_cached[owner_reg];
          l2_valid_next  = 1'b1;
          state_next     = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        // A flush coinciding with acceptance cannot recall the request, so it drains as a discard.
        if (i_l2_ready) begin
          l2_valid_next = 1'b0;
          discard_next  = i_clear;
          state_next    = ARB_WAIT;
        end else if (i_clear) begin
          l2_valid_next = 1'b0;
          state_next    = ARB_IDLE;
        end
      end
      ARB_WAIT: begin
        if (i_l2_resp_valid) begin
          if (discard_reg || i_clear) begin
            discard_next = 1'b0;
            rr_ptr_next  = owner_inc;
            state_next   = ARB_IDLE;
          end else begin
            returned_next[owner_reg] = 1'b1;
            returned_data_next       = i_l2_resp_data;
            state_next               = ARB_RETURN;
          end
        end else if (i_clear) begin
          discard_next = 1'b1;
        end
      end
      ARB_RETURN: begin
        rr_ptr_next = owner_inc;
        state_next  = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg       <= ARB_IDLE;
      owner_reg       <= '0;
      rr_ptr_reg      <= '0;
      discard_reg     <= 1'b0;
      o_l2_valid      <= 1'b0;
      o_l2_paddr      <= '0;
      o_l2_cached     <= 1'b0;
      o_returned      <= '0;
      o_returned_data <= '0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      rr_ptr_reg      <= rr_ptr_next;
      discard_reg     <= discard_next;
      o_l2_valid      <= l2_valid_next;
      o_l2_paddr      <= l2_paddr_next;
      o_l2_cached     <= l2_cached_next;
      o_returned      <= returned_next;
      o_returned_data <= returned_data_next;
    end
  end

`ifdef L2ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            timeout_reg;

  // Counter rests at zero outside ARB_WAIT, so every entry starts a fresh count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else if (state_reg != ARB_WAIT) begin
      wd_cnt_reg <= '0;
    end else if (wd_cnt_reg != WD_W'(TIMEOUT_CYCLES)) begin
      wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
      if (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1)) timeout_reg <= 1'b1;
    end
  end

  assign o_timeout = timeout_reg;
`else
  assign o_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed self-checking bench for l2_req_arbiter (grant order, latency, backpressure, flush, reset).
// Watchdog scenario runs only when built with L2ARB_WATCHDOG_EN.
module tb_l2_req_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 128;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_clear = 1'b0;
  logic [NR-1:0]     i_req = '0;
  logic [NR-1:0]     o_grant;
  logic [NR-1:0]     i_req_valid = '0;
  logic [NR*AW-1:0]  i_req_paddr = '0;
  logic [NR-1:0]     i_req_cached = '0;
  logic [NR-1:0]     o_returned;
  logic [DW-1:0]     o_returned_data;
  logic              o_l2_valid;
  logic [AW-1:0]     o_l2_paddr;
  logic              o_l2_cached;
  logic              i_l2_ready = 1'b1;
  logic              i_l2_resp_valid = 1'b0;
  logic [DW-1:0]     i_l2_resp_data = '0;
  logic              o_busy;
  logic              o_timeout;

  int n_checks = 0;
  int n_fail = 0;
  int accept_cnt = 0;
  int acc0;
  logic [DW-1:0] fill_a5;
  logic [DW-1:0] fill_x;

  l2_req_arbiter #(
    .NUM_REQ(NR), .PADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_req(i_req),
    .o_grant(o_grant), .i_req_valid(i_req_valid), .i_req_paddr(i_req_paddr),
    .i_req_cached(i_req_cached), .o_returned(o_returned),
    .o_returned_data(o_returned_data), .o_l2_valid(o_l2_valid),
    .o_l2_paddr(o_l2_paddr), .o_l2_cached(o_l2_cached), .i_l2_ready(i_l2_ready),
    .i_l2_resp_valid(i_l2_resp_valid), .i_l2_resp_data(i_l2_resp_data),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (o_l2_valid && i_l2_ready) accept_cnt <= accept_cnt + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_paddr(input int k, input logic [AW-1:0] a);
    i_req_paddr[k*AW +: AW] = a;
  endtask

  // Entered in the ARB_IDLE cycle with i_req already driven; leaves in the next ARB_IDLE cycle.
  task automatic txn(input int own, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic [NR-1:0] oh;
    oh = NR'(1) << own;
    settle();
    check_eq("txn_grant", o_grant, oh);
    step();
    i_req_valid = oh;
    set_paddr(own, addr);
    i_req_cached = oh;
    settle();
    check_eq("txn_capture_l2_idle", o_l2_valid, 1'b0);
    step();
    i_req_valid = '0;
    settle();
    check_eq("txn_issue_valid", o_l2_valid, 1'b1);
    check_eq("txn_issue_paddr", o_l2_paddr, addr);
    step();
    check_eq("txn_wait_l2_idle", o_l2_valid, 1'b0);
    i_l2_resp_valid = 1'b1;
    i_l2_resp_data = data;
    step();
    i_l2_resp_valid = 1'b0;
    settle();
    check_eq("txn_returned", o_returned, oh);
    check_eq("txn_returned_data", o_returned_data, data);
    step();
    settle();
    check_eq("txn_returned_clear", o_returned, '0);
    check_eq("txn_idle", o_busy, 1'b0);
    $display("txn owner=%0d paddr=%h data=%h", own, addr, data);
  endtask

  initial begin
    fill_a5 = {16{8'hA5}};
    fill_x  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    // Reset state
    step();
    step();
    check_eq("rst_grant", o_grant, '0);
    check_eq("rst_busy", o_busy, 1'b0);
    check_eq("rst_l2_valid", o_l2_valid, 1'b0);
    check_eq("rst_paddr", o_l2_paddr, '0);
    check_eq("rst_returned", o_returned, '0);
    check_eq("rst_timeout", o_timeout, 1'b0);
    i_rst_n = 1'b1;

    // Single requester with the reference timing
    step();
    i_req = 2'b01;
    settle();
    check_eq("t1_grant", o_grant, 2'b01);
    check_eq("t1_busy_T", o_busy, 1'b0);
    step();
    i_req = 2'b00;
    i_req_valid = 2'b01;
    set_paddr(0, 32'h0000_1040);
    i_req_cached = 2'b01;
    settle();
    check_eq("t1_busy_T1", o_busy, 1'b1);
    check_eq("t1_grant_T1", o_grant, '0);
    step();
    i_req_valid = '0;
    settle();
    check_eq("t1_l2_valid", o_l2_valid, 1'b1);
    check_eq("t1_l2_paddr", o_l2_paddr, 32'h0000_1040);
    check_eq("t1_l2_cached", o_l2_cached, 1'b1);
    step();
    check_eq("t1_l2_valid_drop", o_l2_valid, 1'b0);
    step();
    step();
    i_l2_resp_valid = 1'b1;
    i_l2_resp_data = fill_a5;
    step();
    i_l2_resp_valid = 1'b0;
    settle();
    check_eq("t1_returned", o_returned, 2'b01);
    check_eq("t1_returned_data", o_returned_data, fill_a5);
    step();
    settle();
    check_eq("t1_busy_T7", o_busy, 1'b0);
    check_eq("t1_returned_T7", o_returned, '0);
    check_eq("t1_data_T7", o_returned_data, '0);
    $display("txn owner=0 paddr=00001040 data=%h", fill_a5);

    // Contention from a fresh reset: 01, 10, 01
    i_rst_n = 1'b0;
    settle();
    i_rst_n = 1'b1;
    i_req = 2'b11;
    txn(0, 32'h0000_0100, fill_x);
    txn(1, 32'h0000_0200, ~fill_x);
    txn(0, 32'h0000_0300, fill_a5);
    i_req = 2'b00;

    // Backpressure: ready low for 5 ISSUE cycles (rr_ptr is 1, only requester 0 asks)
    step();
    i_req = 2'b01;
    settle();
    check_eq("bp_grant", o_grant, 2'b01);
    step();
    i_req = 2'b00;
    i_req_valid = 2'b01;
    set_paddr(0, 32'h2000_0080);
    i_l2_ready = 1'b0;
    acc0 = accept_cnt;
    step();
    i_req_valid = '0;
    settle();
    check_eq("bp_valid_1", o_l2_valid, 1'b1);
    check_eq("bp_paddr_1", o_l2_paddr, 32'h2000_0080);
    for (int j = 1; j <= 5; j++) begin
      step();
      settle();
      check_eq("bp_valid_held", o_l2_valid, 1'b1);
      check_eq("bp_paddr_held", o_l2_paddr, 32'h2000_0080);
      if (j == 5) i_l2_ready = 1'b1;
    end
    step();
    settle();
    check_eq("bp_valid_after_accept", o_l2_valid, 1'b0);
    check_eq("bp_busy_wait", o_busy, 1'b1);
    i_l2_resp_valid = 1'b1;
    i_l2_resp_data = fill_x;
    step();
    i_l2_resp_valid = 1'b0;
    settle();
    check_eq("bp_returned", o_returned, 2'b01);
    check_eq("bp_accept_count", accept_cnt - acc0, 1);
    step();
    $display("txn owner=0 paddr=20000080 backpressure accepts=%0d", accept_cnt - acc0);

    // Clear during ARB_ISSUE
    i_req = 2'b01;
    settle();
    check_eq("clr_issue_grant", o_grant, 2'b01);
    step();
    i_req = 2'b00;
    i_req_valid = 2'b01;
    set_paddr(0, 32'h0000_5000);
    i_l2_ready = 1'b0;
    step();
    i_req_valid = '0;
    settle();
    check_eq("clr_issue_valid", o_l2_valid, 1'b1);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    settle();
    check_eq("clr_issue_valid_drop", o_l2_valid, 1'b0);
    check_eq("clr_issue_idle", o_busy, 1'b0);
    i_l2_resp_valid = 1'b1;
    step();
    i_l2_resp_valid = 1'b0;
    i_l2_ready = 1'b1;
    settle();
    check_eq("clr_issue_no_return", o_returned, '0);
    $display("txn owner=0 paddr=00005000 cleared in issue");

    // Clear during ARB_WAIT, fill 3 cycles later (rr_ptr unchanged at 1)
    i_req = 2'b10;
    settle();
    check_eq("clr_wait_grant", o_grant, 2'b10);
    step();
    i_req = 2'b00;
    i_req_valid = 2'b10;
    set_paddr(1, 32'h0000_3000);
    step();
    i_req_valid = '0;
    step();
    i_clear = 1'b1;
    settle();
    check_eq("clr_wait_busy", o_busy, 1'b1);
    step();
    i_clear = 1'b0;
    step();
    step();
    i_l2_resp_valid = 1'b1;
    i_l2_resp_data = fill_x;
    settle();
    check_eq("clr_wait_busy_before_fill", o_busy, 1'b1);
    step();
    i_l2_resp_valid = 1'b0;
    settle();
    check_eq("clr_wait_idle", o_busy, 1'b0);
    check_eq("clr_wait_no_return", o_returned, '0);
    i_req = 2'b11;
    settle();
    check_eq("clr_wait_rr_advanced", o_grant, 2'b01);
    i_clear = 1'b1;
    settle();
    check_eq("clr_idle_no_grant", o_grant, '0);
    step();
    i_clear = 1'b0;
    i_req = 2'b00;
    settle();
    check_eq("clr_idle_stays", o_busy, 1'b0);
    $display("txn owner=1 paddr=00003000 cleared in wait");

    // Asynchronous reset while in ARB_WAIT
    i_req = 2'b01;
    step();
    i_req = 2'b00;
    i_req_valid = 2'b01;
    set_paddr(0, 32'h0000_4000);
    step();
    i_req_valid = '0;
    step();
    settle();
    check_eq("rstw_busy", o_busy, 1'b1);
    check_eq("rstw_paddr", o_l2_paddr, 32'h0000_4000);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("rstw_busy_async", o_busy, 1'b0);
    check_eq("rstw_paddr_async", o_l2_paddr, '0);
    check_eq("rstw_cached_async", o_l2_cached, 1'b0);
    step();
    i_rst_n = 1'b1;
    i_l2_resp_valid = 1'b1;
    step();
    i_l2_resp_valid = 1'b0;
    settle();
    check_eq("rstw_stray_no_return", o_returned, '0);
    check_eq("rstw_stray_idle", o_busy, 1'b0);
    $display("txn owner=0 paddr=00004000 reset in wait");

`ifdef L2ARB_WATCHDOG_EN
    // Watchdog: fill delayed 20 ARB_WAIT cycles with TIMEOUT_CYCLES=16
    i_req = 2'b01;
    step();
    i_req = 2'b00;
    i_req_valid = 2'b01;
    set_paddr(0, 32'h0000_6000);
    step();
    i_req_valid = '0;
    step();
    for (int w = 1; w <= 20; w++) begin
      settle();
      if (w == 15) check_eq("wd_not_yet", o_timeout, 1'b0);
      if (w == 18) check_eq("wd_raised", o_timeout, 1'b1);
      if (w == 20) begin
        i_l2_resp_valid = 1'b1;
        i_l2_resp_data = fill_a5;
      end
      step();
    end
    i_l2_resp_valid = 1'b0;
    settle();
    check_eq("wd_returned", o_returned, 2'b01);
    check_eq("wd_sticky", o_timeout, 1'b1);
    step();
    $display("txn owner=0 paddr=00006000 watchdog");
`else
    check_eq("wd_absent", o_timeout, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
